// File: rtl/wb_ram_slave.sv
// Wishbone B4 word-organised RAM responder: classic cycles with programmable wait states and
// incrementing bursts at one beat per clock. Out-of-range or misaligned accesses end with ERR.
module wb_ram_slave #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CYC,
  input  logic        STB,
  input  logic        WE,
  input  logic [31:0] ADR,
  input  logic [31:0] DAT_I,
  input  logic [2:0]  CTI_I,
  output logic [31:0] DAT_O,
  output logic        ACK,
  output logic        ERR,
  output logic        RTY
);

  localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SizeBytes = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WaitInit  = 4'(WAIT_STATES);
  localparam logic [AW-1:0] TopIdx  = AW'(DEPTH_WORDS - 1);
  localparam logic [2:0]  CtiIncr   = 3'b010;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StAck,
    StBurst,
    StErr
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          we_q, we_d;
  logic [2:0]    cti_q, cti_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   last_q, last_d;
  logic [31:0]   rd_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          mem_we;
  logic          ack, err;
  logic [31:0]   offset;
  logic          addr_ok;
  logic [AW-1:0] req_idx;

  // Unsigned subtraction also rejects addresses below the base (they wrap to huge offsets).
  assign offset  = ADR - BASE_ADDR;
  assign addr_ok = ({1'b0, offset} < SizeBytes) && (ADR[1:0] == 2'b00);
  assign req_idx = offset[AW+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    we_d    = we_q;
    cti_d   = cti_q;
    ovf_d   = ovf_q;
    mem_we  = 1'b0;
    ack     = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (CYC && STB) begin
          we_d  = WE;
          cti_d = CTI_I;
          ovf_d = 1'b0;
          if (!addr_ok) begin
            state_d = StErr;
          end else begin
            ptr_d   = req_idx;
            cnt_d   = WaitInit;
            state_d = (WAIT_STATES == 0) ? StAck : StWait;
          end
        end
      end
      StWait: begin
        if (!CYC) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_d = StAck;
        end
      end
      StAck: begin
        ack = 1'b1;
        if (!CYC) begin
          state_d = StIdle;
        end else begin
          mem_we = we_q;
          if (cti_q == CtiIncr && STB && CTI_I == CtiIncr) begin
            state_d = StBurst;
            ptr_d   = ptr_q + 1'b1;
            // Top word consumed: the next beat has nowhere to go and must be refused.
            ovf_d   = (ptr_q == TopIdx);
          end else begin
            state_d = StIdle;
          end
        end
      end
      StBurst: begin
        if (!CYC) begin
          state_d = StIdle;
        end else if (STB) begin
          if (ovf_q) begin
            err     = 1'b1;
            state_d = StIdle;
          end else begin
            ack    = 1'b1;
            mem_we = WE;
            if (CTI_I == CtiIncr) begin
              ptr_d = ptr_q + 1'b1;
              ovf_d = (ptr_q == TopIdx);
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      StErr: begin
        err     = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // DAT_O shows the prefetched word during ACK and otherwise keeps the last value presented.
  assign last_d = ack ? rd_q : last_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      ptr_q   <= '0;
      we_q    <= 1'b0;
      cti_q   <= 3'b000;
      ovf_q   <= 1'b0;
      last_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      cti_q   <= cti_d;
      ovf_q   <= ovf_d;
      last_q  <= last_d;
    end
  end

  // Read address is the pointer of the coming cycle, so the word is ready on the ACK cycle.
  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr_q] <= DAT_I;
    rd_q <= mem[ptr_d];
  end

  assign DAT_O = ack ? rd_q : last_q;
  assign ACK   = ack;
  assign ERR   = err;
  assign RTY   = 1'b0;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Self-checking bench for wb_ram_slave: two instances (0 and 3 wait states) driven by directed
// and random classic/burst transactions, checked against a word-array memory model.
module tb_wb_ram_slave;

  localparam int unsigned Depth = 64;
  localparam logic [31:0] Base  = 32'h0000_0400;
  localparam int unsigned Ws0   = 0;
  localparam int unsigned Ws1   = 3;
  localparam int TermAck = 4;  // {ack, err, rty}
  localparam int TermErr = 2;

  logic        clk;
  logic        rst;
  logic        cyc, stb, we;
  logic [31:0] adr, dat_w;
  logic [2:0]  cti;
  logic        sel;
  logic        cyc0, cyc1;
  logic [31:0] dat0, dat1, rdat;
  logic [1:0]  ack_v, err_v, rty_v;
  logic        ack, err, rty;

  logic [31:0] mem_m [2][Depth];
  int n_vec;
  int n_err;

  assign cyc0 = cyc & (sel == 1'b0);
  assign cyc1 = cyc & (sel == 1'b1);
  assign rdat = sel ? dat1 : dat0;
  assign ack  = ack_v[sel];
  assign err  = err_v[sel];
  assign rty  = rty_v[sel];

  wb_ram_slave #(.DEPTH_WORDS(Depth), .BASE_ADDR(Base), .WAIT_STATES(Ws0)) u_dut0 (
    .clk(clk), .rst(rst), .CYC(cyc0), .STB(stb), .WE(we), .ADR(adr), .DAT_I(dat_w),
    .CTI_I(cti), .DAT_O(dat0), .ACK(ack_v[0]), .ERR(err_v[0]), .RTY(rty_v[0])
  );

  wb_ram_slave #(.DEPTH_WORDS(Depth), .BASE_ADDR(Base), .WAIT_STATES(Ws1)) u_dut1 (
    .clk(clk), .rst(rst), .CYC(cyc1), .STB(stb), .WE(we), .ADR(adr), .DAT_I(dat_w),
    .CTI_I(cti), .DAT_O(dat1), .ACK(ack_v[1]), .ERR(err_v[1]), .RTY(rty_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] waddr(input int idx);
    return Base + 32'(idx) * 32'd4;
  endfunction

  function automatic bit addr_ok(input logic [31:0] a);
    logic [31:0] off;
    off = a - Base;
    return (off < 32'(Depth * 4)) && (a[1:0] == 2'b00);
  endfunction

  function automatic int ws_of(input logic s);
    return s ? int'(Ws1) : int'(Ws0);
  endfunction

  function automatic logic [31:0] rand_addr();
    int p;
    int idx;
    p = $urandom_range(99);
    if (p < 20) idx = Depth - $urandom_range(1, 4);
    else idx = $urandom_range(Depth - 1);
    if (p < 80) return waddr(idx);
    if (p < 88) return waddr(idx) | 32'($urandom_range(1, 3));
    if (p < 94) return waddr(Depth + idx);
    return Base - 32'(4 * $urandom_range(1, 8));
  endfunction

  task automatic bus_idle();
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
    cti = 3'b000;
  endtask

  // Cycles from the request cycle (0) to the first termination, or -1 if none arrives.
  task automatic wait_term(input int budget, output int lat);
    lat = -1;
    for (int k = 0; k <= budget; k++) begin
      @(negedge clk);
      if (ack || err) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic classic(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input string tag);
    int lat;
    bit ok;
    int idx;
    ok  = addr_ok(a);
    idx = ok ? int'((a - Base) >> 2) : 0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; cti = 3'b000;
    wait_term(40, lat);
    check_eq({tag, ".lat"}, lat, ok ? ws_of(sel) + 1 : 1);
    check_eq({tag, ".term"}, 32'({ack, err, rty}), ok ? TermAck : TermErr);
    if (ok && !w) check_eq({tag, ".rdata"}, rdat, mem_m[sel][idx]);
    @(posedge clk); #1;
    if (ok && w && lat >= 0) mem_m[sel][idx] = d;
    bus_idle();
    @(negedge clk);
    check_eq({tag, ".drop"}, 32'({ack, err}), 0);
    if (ok && !w) check_eq({tag, ".hold"}, rdat, mem_m[sel][idx]);
  endtask

  // wmode: 0 read, 1 write, 2 random per beat.
  task automatic burst(input logic [31:0] a, input int n, input int wmode, input int stall_pct,
                       input bit count_data, input string tag);
    int lat;
    bit ok;
    int idx0;
    int widx;
    logic w;
    logic [31:0] d;
    ok   = addr_ok(a);
    idx0 = ok ? int'((a - Base) >> 2) : 0;
    w    = (wmode == 2) ? 1'($urandom_range(1)) : 1'(wmode);
    d    = count_data ? 32'd1 : $urandom;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; cti = (n > 1) ? 3'b010 : 3'b111;
    wait_term(40, lat);
    check_eq({tag, ".lat"}, lat, ok ? ws_of(sel) + 1 : 1);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        if ($urandom_range(99) < stall_pct) begin
          stb = 1'b0;
          @(negedge clk);
          check_eq({tag, ".stall"}, 32'({ack, err}), 0);
          @(posedge clk); #1;
        end
        w = (wmode == 2) ? 1'($urandom_range(1)) : 1'(wmode);
        d = count_data ? 32'(i + 1) : $urandom;
        stb = 1'b1; we = w; dat_w = d; adr = a + 32'(4 * i);
        cti = (i == n - 1) ? 3'b111 : 3'b010;
        @(negedge clk);
      end
      widx = idx0 + i;
      if (!ok || widx >= int'(Depth)) begin
        check_eq({tag, ".term"}, 32'({ack, err, rty}), TermErr);
        break;
      end
      check_eq({tag, ".term"}, 32'({ack, err, rty}), TermAck);
      if (!w) check_eq({tag, ".rdata"}, rdat, mem_m[sel][widx]);
      else mem_m[sel][widx] = d;
    end
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    check_eq({tag, ".drop"}, 32'({ack, err}), 0);
  endtask

  task automatic abort_drop(input int idx);
    logic [31:0] d;
    logic seen;
    d = ~mem_m[sel][idx];
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = waddr(idx); dat_w = d; cti = 3'b000;
    @(posedge clk); #1;
    bus_idle();
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | ack | err;
    end
    check_eq("abort.noterm", 32'(seen), 0);
  endtask

  task automatic reset_mid(input int idx);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = waddr(idx); dat_w = ~mem_m[sel][idx];
    cti = 3'b000;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_eq("rst_mid.term", 32'({ack, err, rty}), 0);
    check_eq("rst_mid.dat", rdat, 32'd0);
    bus_idle();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    sel   = 1'b0;
    adr   = '0;
    dat_w = '0;
    bus_idle();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    check_eq("rst.dat0", dat0, 32'd0);
    check_eq("rst.dat1", dat1, 32'd0);
    check_eq("rst.term0", 32'({ack_v[0], err_v[0], rty_v[0]}), 0);
    check_eq("rst.term1", 32'({ack_v[1], err_v[1], rty_v[1]}), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      for (int i = 0; i < int'(Depth); i++) classic(1'b1, waddr(i), $urandom, "fill");
    end

    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      classic(1'b1, waddr(4), 32'hDEAD_BEEF, "wr10");
      classic(1'b0, waddr(4), 32'h0, "rd10");
      classic(1'b1, waddr(0), 32'h1234_5678, "wr00");
      classic(1'b0, waddr(0), 32'h0, "rd00");
      burst(waddr(8), 4, 1, 0, 1'b1, "bwr20");
      burst(waddr(8), 4, 0, 0, 1'b0, "brd20");
      classic(1'b1, waddr(8) + 32'd2, 32'hFFFF_FFFF, "mis22");
      classic(1'b1, Base + 32'(Depth * 4), 32'hFFFF_FFFF, "oor_hi");
      classic(1'b1, Base - 32'd4, 32'hFFFF_FFFF, "oor_lo");
      classic(1'b0, waddr(8), 32'h0, "rd20_after_err");
      burst(waddr(Depth - 1), 2, 0, 0, 1'b0, "btop");
      burst(waddr(Depth - 3), 5, 2, 40, 1'b0, "btop_mix");
    end

    sel = 1'b1;
    abort_drop(16);
    classic(1'b0, waddr(16), 32'h0, "rd40_after_abort");
    classic(1'b0, waddr(0), 32'h0, "rd00_pre_rst");
    reset_mid(16);
    classic(1'b0, waddr(16), 32'h0, "rd40_after_rst");
    classic(1'b0, waddr(0), 32'h0, "rd00_after_rst");

    for (int t = 0; t < 200; t++) begin
      logic [31:0] a;
      sel = 1'($urandom_range(1));
      a = rand_addr();
      if ($urandom_range(99) < 55) classic(1'($urandom_range(1)), a, $urandom, "rnd.cl");
      else burst(a, $urandom_range(2, 6), 2, 30, 1'b0, "rnd.bu");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
